// File: rtl/rotate_pkg.sv
// rotate_pkg: constants and types shared by the rotation read bridge.
// Pixel size, coordinate field layout and the address pipeline bundle.
package rotate_pkg;

    localparam int PIX_BYTES = 2;
    localparam int COORD_W   = 11;
    localparam int X_LSB     = 16;
    localparam int Y_LSB     = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] row;
        logic [31:0] x;
    } addr_s1_t;

    function automatic logic [COORD_W-1:0] coord_x(input logic [31:0] c);
        return c[X_LSB +: COORD_W];
    endfunction

    function automatic logic [COORD_W-1:0] coord_y(input logic [31:0] c);
        return c[Y_LSB +: COORD_W];
    endfunction

endpackage

// File: rtl/rd_req_fifo.sv
// rd_req_fifo: synchronous first-word-fall-through request FIFO.
// Ports: wr_en/wr_data push, rd_en pop, rd_data head, full, count.
module rd_req_fifo
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (count == FULL_CNT);
    assign pop     = rd_en & (count != '0);
    // A pop in the same cycle frees the slot a full-FIFO write needs.
    assign push    = wr_en & (~full | pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rotate_ddr_rd_bridge.sv
// rotate_ddr_rd_bridge: turns rotated pixel coordinates into DDR reads.
// Ports: coord in, ddr_rd_req/ddr_rd_data, pix out, sticky errors.
module rotate_ddr_rd_bridge
    import rotate_pkg::*;
#(
    parameter int          IMAGE_W         = 1280,
    parameter int          IMAGE_H         = 720,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          REQ_DEPTH       = 16,
    parameter int          MAX_OUTSTANDING = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coord_valid,
    input  logic [31:0] coord,
    output logic        ddr_rd_req_valid,
    input  logic        ddr_rd_req_ready,
    output logic [31:0] ddr_rd_addr,
    input  logic        ddr_rd_data_valid,
    input  logic [15:0] ddr_rd_data,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    input  logic        err_clr,
    output logic        ovf_err,
    output logic        range_err,
    output logic        unexp_err,
    output logic [7:0]  outstanding
);

    localparam int          CW      = $clog2(REQ_DEPTH) + 1;
    localparam logic [31:0] X_MAX   = 32'(IMAGE_W - 1);
    localparam logic [31:0] Y_MAX   = 32'(IMAGE_H - 1);
    localparam logic [31:0] LINE_W  = 32'(IMAGE_W);
    localparam logic [31:0] PIX_SZ  = 32'(PIX_BYTES);
    localparam logic [7:0]  OUT_MAX = 8'(MAX_OUTSTANDING);

    logic [31:0]   x_in;
    logic [31:0]   y_in;
    logic [31:0]   x_c;
    logic [31:0]   y_c;
    logic          x_oob;
    logic          y_oob;
    addr_s1_t      s1;
    logic          s2_valid;
    logic [31:0]   s2_addr;
    logic [31:0]   fifo_head;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          req_ok;
    logic          xfer;
    logic          ret;
    logic          range_ev;
    logic          ovf_ev;
    logic          unexp_ev;

    // Out-of-range coordinates are clamped, not dropped, so every
    // coordinate still yields exactly one pixel.
    always_comb begin
        x_in  = 32'(coord_x(coord));
        y_in  = 32'(coord_y(coord));
        x_oob = x_in > X_MAX;
        y_oob = y_in > Y_MAX;
        x_c   = x_oob ? X_MAX : x_in;
        y_c   = y_oob ? Y_MAX : y_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
        end else begin
            s1.valid <= coord_valid;
            s1.row   <= y_c * LINE_W;
            s1.x     <= x_c;
            s2_valid <= s1.valid;
            s2_addr  <= BASE_ADDR + (s1.row + s1.x) * PIX_SZ;
        end
    end

    rd_req_fifo #(
        .DEPTH (REQ_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s2_valid),
        .wr_data (s2_addr),
        .rd_en   (xfer),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign req_ok           = (fifo_count != '0) && (outstanding < OUT_MAX);
    assign ddr_rd_req_valid = req_ok;
    assign ddr_rd_addr      = req_ok ? fifo_head : '0;
    assign xfer             = req_ok & ddr_rd_req_ready;
    assign ret              = ddr_rd_data_valid & (outstanding != '0);
    assign unexp_ev         = ddr_rd_data_valid & (outstanding == '0);
    assign ovf_ev           = s2_valid & fifo_full & ~xfer;
    assign range_ev         = coord_valid & (x_oob | y_oob);

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            ovf_err     <= 1'b0;
            range_err   <= 1'b0;
            unexp_err   <= 1'b0;
        end else begin
            unique case ({xfer, ret})
                2'b10:   outstanding <= outstanding + 8'd1;
                2'b01:   outstanding <= outstanding - 8'd1;
                default: outstanding <= outstanding;
            endcase
            pix_valid <= ret;
            pix_data  <= ret ? ddr_rd_data : 16'h0;
            // A new error in the clearing cycle keeps its flag set.
            ovf_err   <= (ovf_err & ~err_clr) | ovf_ev;
            range_err <= (range_err & ~err_clr) | range_ev;
            unexp_err <= (unexp_err & ~err_clr) | unexp_ev;
        end
    end

endmodule

// File: tb/tb_rotate_ddr_rd_bridge.sv
// tb_rotate_ddr_rd_bridge: directed bench with a queue-based model.
// Checks every output each cycle plus hand-computed expectations.
module tb_rotate_ddr_rd_bridge;

    localparam int          W     = 1280;
    localparam int          H     = 720;
    localparam int          DEPTH = 16;
    localparam int          MAXO  = 16;
    localparam logic [31:0] BASE  = 32'h0;

    bit          clk;
    logic        rst;
    logic        coord_valid;
    logic [31:0] coord;
    logic        ddr_rd_req_valid;
    logic        ddr_rd_req_ready;
    logic [31:0] ddr_rd_addr;
    logic        ddr_rd_data_valid;
    logic [15:0] ddr_rd_data;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        err_clr;
    logic        ovf_err;
    logic        range_err;
    logic        unexp_err;
    logic [7:0]  outstanding;

    int checks = 0;
    int errors = 0;

    rotate_ddr_rd_bridge #(
        .IMAGE_W         (W),
        .IMAGE_H         (H),
        .BASE_ADDR       (BASE),
        .REQ_DEPTH       (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .coord_valid       (coord_valid),
        .coord             (coord),
        .ddr_rd_req_valid  (ddr_rd_req_valid),
        .ddr_rd_req_ready  (ddr_rd_req_ready),
        .ddr_rd_addr       (ddr_rd_addr),
        .ddr_rd_data_valid (ddr_rd_data_valid),
        .ddr_rd_data       (ddr_rd_data),
        .pix_valid         (pix_valid),
        .pix_data          (pix_data),
        .err_clr           (err_clr),
        .ovf_err           (ovf_err),
        .range_err         (range_err),
        .unexp_err         (unexp_err),
        .outstanding       (outstanding)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Ignored coordinate bits carry junk to prove they are ignored.
    function automatic logic [31:0] mk(input logic [10:0] x,
                                       input logic [10:0] y);
        return {5'b10101, x, 5'b01010, y};
    endfunction

    function automatic bit oob(input logic [31:0] c);
        return (32'(c[26:16]) >= W) || (32'(c[10:0]) >= H);
    endfunction

    function automatic logic [31:0] addr_of(input logic [31:0] c);
        int unsigned x;
        int unsigned y;
        x = 32'(c[26:16]);
        y = 32'(c[10:0]);
        if (x >= W) x = W - 1;
        if (y >= H) y = H - 1;
        return BASE + 2 * (y * W + x);
    endfunction

    // Behavioural model: coordinates take two cycles to reach a queue,
    // the queue feeds requests, a counter tracks reads in flight.
    logic [31:0] mq[$];
    bit          p1_v, p2_v;
    logic [31:0] p1_a, p2_a;
    int          m_outs;
    bit          m_pix_v;
    logic [15:0] m_pix_d;
    bit          m_ovf, m_rng, m_unx;
    bit          live;

    always @(posedge clk) begin
        bit rv, xfer, ret, ovf_ev;
        live = 1;
        if (rst) begin
            mq.delete();
            p1_v = 0; p2_v = 0;
            m_outs = 0;
            m_pix_v = 0; m_pix_d = 0;
            m_ovf = 0; m_rng = 0; m_unx = 0;
        end else begin
            rv   = (mq.size() > 0) && (m_outs < MAXO);
            xfer = rv && ddr_rd_req_ready;
            ret  = ddr_rd_data_valid && (m_outs > 0);
            if (xfer) void'(mq.pop_front());
            ovf_ev = 0;
            if (p2_v) begin
                if (mq.size() < DEPTH) mq.push_back(p2_a);
                else ovf_ev = 1;
            end
            m_outs = m_outs + int'(xfer) - int'(ret);
            m_pix_v = ret;
            m_pix_d = ret ? ddr_rd_data : 16'h0;
            m_ovf = (m_ovf && !err_clr) || ovf_ev;
            m_unx = (m_unx && !err_clr) ||
                    (ddr_rd_data_valid && m_outs == 0 && !ret && !xfer) ||
                    (ddr_rd_data_valid && !ret);
            m_rng = (m_rng && !err_clr) || (coord_valid && oob(coord));
            p2_v = p1_v; p2_a = p1_a;
            p1_v = coord_valid; p1_a = addr_of(coord);
        end
    end

    always @(negedge clk) begin
        logic        ev;
        logic [31:0] ea;
        if (live) begin
            ev = (mq.size() > 0) && (m_outs < MAXO);
            ea = ev ? mq[0] : 32'h0;
            chk("req_valid", 32'(ddr_rd_req_valid), 32'(ev));
            chk("req_addr", ddr_rd_addr, ea);
            chk("outstanding", 32'(outstanding), 32'(m_outs));
            chk("pix_valid", 32'(pix_valid), 32'(m_pix_v));
            chk("pix_data", 32'(pix_data), 32'(m_pix_d));
            chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
            chk("range_err", 32'(range_err), 32'(m_rng));
            chk("unexp_err", 32'(unexp_err), 32'(m_unx));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [10:0] x, input logic [10:0] y);
        coord_valid = 1'b1;
        coord = mk(x, y);
        tick();
        coord_valid = 1'b0;
        coord = 32'hFFFF_FFFF;
    endtask

    task automatic beat(input logic [15:0] d);
        ddr_rd_data_valid = 1'b1;
        ddr_rd_data = d;
        tick();
        ddr_rd_data_valid = 1'b0;
        ddr_rd_data = 16'h0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        coord_valid = 1'b0;
        coord = 32'h0;
        ddr_rd_req_ready = 1'b0;
        ddr_rd_data_valid = 1'b0;
        ddr_rd_data = 16'h0;
        err_clr = 1'b0;
        idle(3);
        rst = 1'b0;
        chk("rst_req_valid", 32'(ddr_rd_req_valid), 32'h0);
        chk("rst_outstanding", 32'(outstanding), 32'h0);
        chk("rst_pix_valid", 32'(pix_valid), 32'h0);
        chk("rst_flags", {29'h0, ovf_err, range_err, unexp_err}, 32'h0);

        // Corner addresses and three-cycle latency.
        send(11'd0, 11'd0);
        send(11'd1279, 11'd719);
        chk("lat_not_yet", 32'(ddr_rd_req_valid), 32'h0);
        tick();
        chk("lat_valid0", 32'(ddr_rd_req_valid), 32'h1);
        chk("addr_origin", ddr_rd_addr, 32'h0);
        ddr_rd_req_ready = 1'b1;
        tick();
        chk("lat_valid1", 32'(ddr_rd_req_valid), 32'h1);
        chk("addr_corner", ddr_rd_addr, 32'h001C_1FFE);
        tick();
        ddr_rd_req_ready = 1'b0;
        chk("two_in_flight", 32'(outstanding), 32'h2);
        beat(16'h1111);
        chk("pix_1111", 32'(pix_data), 32'h1111);
        beat(16'h2222);
        idle(1);
        chk("pix_idle_zero", {15'h0, pix_valid, pix_data}, 32'h0);

        // Clamping, range flag, clear versus simultaneous event.
        send(11'd2000, 11'd800);
        chk("range_set", 32'(range_err), 32'h1);
        idle(2);
        chk("clamp_addr", ddr_rd_addr, 32'h001C_1FFE);
        ddr_rd_req_ready = 1'b1;
        tick();
        ddr_rd_req_ready = 1'b0;
        beat(16'h5555);
        coord_valid = 1'b1;
        coord = mk(11'd1500, 11'd10);
        err_clr = 1'b1;
        tick();
        coord_valid = 1'b0;
        err_clr = 1'b0;
        chk("range_event_wins", 32'(range_err), 32'h1);
        clear_errs();
        chk("range_cleared", 32'(range_err), 32'h0);
        ddr_rd_req_ready = 1'b1;
        idle(4);
        ddr_rd_req_ready = 1'b0;
        beat(16'h6666);

        // Overflow: 17 coordinates into a 16-deep queue.
        for (int i = 0; i < 17; i++) send(11'(i), 11'd0);
        idle(2);
        chk("ovf_set", 32'(ovf_err), 32'h1);
        ddr_rd_req_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", 32'(ddr_rd_req_valid), 32'h1);
            chk("drain_addr", ddr_rd_addr, 32'(2 * i));
            tick();
        end
        chk("drain_done", 32'(ddr_rd_req_valid), 32'h0);
        chk("drain_outs", 32'(outstanding), 32'd16);
        ddr_rd_req_ready = 1'b0;
        for (int i = 0; i < 16; i++) beat(16'(i));
        chk("returned_all", 32'(outstanding), 32'h0);
        clear_errs();

        // Outstanding limit throttles requests.
        ddr_rd_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(11'(100 + i), 11'd1);
        idle(25);
        chk("limit_outs", 32'(outstanding), 32'd16);
        chk("limit_blocked", 32'(ddr_rd_req_valid), 32'h0);
        beat(16'h0007);
        chk("limit_reopen", 32'(ddr_rd_req_valid), 32'h1);
        tick();
        chk("limit_refill", 32'(outstanding), 32'd16);
        for (int k = 0; k < 60 && (outstanding != 0 || ddr_rd_req_valid); k++) begin
            ddr_rd_data_valid = (outstanding != 0);
            ddr_rd_data = 16'(16'h0100 + k);
            tick();
        end
        ddr_rd_data_valid = 1'b0;
        chk("full_rate_drained", 32'(outstanding), 32'h0);

        // Unexpected beat, then a matched one.
        beat(16'hBEEF);
        chk("unexp_no_pix", 32'(pix_valid), 32'h0);
        chk("unexp_set", 32'(unexp_err), 32'h1);
        clear_errs();
        send(11'd5, 11'd5);
        idle(3);
        ddr_rd_req_ready = 1'b0;
        chk("one_in_flight", 32'(outstanding), 32'h1);
        beat(16'hABCD);
        chk("abcd_valid", 32'(pix_valid), 32'h1);
        chk("abcd_data", 32'(pix_data), 32'hABCD);
        chk("abcd_outs", 32'(outstanding), 32'h0);

        // Reset with queued and in-flight work.
        ddr_rd_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(11'(i), 11'd2);
        idle(5);
        ddr_rd_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(11'(i), 11'd3);
        idle(3);
        chk("pre_rst_outs", 32'(outstanding), 32'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(ddr_rd_req_valid), 32'h0);
        chk("mid_rst_addr", ddr_rd_addr, 32'h0);
        chk("mid_rst_outs", 32'(outstanding), 32'h0);
        ddr_rd_req_ready = 1'b1;
        idle(3);
        for (int i = 0; i < 3; i++) begin
            beat(16'(16'h0A00 + i));
            chk("late_no_pix", 32'(pix_valid), 32'h0);
        end
        chk("late_unexp", 32'(unexp_err), 32'h1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
